// File: rtl/dbg_bus_pkg.sv
// Shared types and constants for the debug memory-access bridge.
package dbg_bus_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_REQ  = 2'd1,
      ST_WAIT = 2'd2,
      ST_RSP  = 2'd3
   } dbg_state_t;

   localparam logic [3:0] SEL_WORD = 4'b1111;

   localparam logic [3:0] WEN_READ = 4'b0000;
   localparam logic [3:0] WEN_B0   = 4'b0001;
   localparam logic [3:0] WEN_B1   = 4'b0010;
   localparam logic [3:0] WEN_B2   = 4'b0100;
   localparam logic [3:0] WEN_B3   = 4'b1000;
   localparam logic [3:0] WEN_H0   = 4'b0011;
   localparam logic [3:0] WEN_H1   = 4'b1100;
   localparam logic [3:0] WEN_WORD = 4'b1111;

   // Only naturally aligned byte, halfword and word lane patterns are legal.
   function automatic logic wen_legal(input logic [3:0] wen);
      case (wen)
         WEN_READ, WEN_B0, WEN_B1, WEN_B2, WEN_B3,
         WEN_H0, WEN_H1, WEN_WORD: return 1'b1;
         default:                  return 1'b0;
      endcase
   endfunction

endpackage

// File: rtl/dbg_timeout_cnt.sv
// Response timeout counter: cleared at request issue, expires on its LIMIT-th enabled cycle.
module dbg_timeout_cnt #(
   parameter int unsigned LIMIT = 255
) (
   input  logic clk,
   input  logic rst,
   input  logic clr,
   input  logic en,
   output logic expired
);

   localparam int unsigned CW = $clog2(LIMIT + 1);

   logic [CW-1:0] cnt;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt <= '0;
      end else if (clr) begin
         cnt <= '0;
      end else if (en && !expired) begin
         cnt <= cnt + 1'b1;
      end
   end

   assign expired = en && (cnt == CW'(LIMIT - 1));

endmodule

// File: rtl/dbg_bus_bridge.sv
// Debug memory-access bridge: one word access at a time from the debug module to the system bus.
// Optional response timeout and late-response drain enabled by DBG_BRIDGE_TIMEOUT_EN.
module dbg_bus_bridge
   import dbg_bus_pkg::*;
#(
   parameter int unsigned ADDR_W         = 32,
   parameter int unsigned DATA_W         = 32,
   parameter int unsigned TIMEOUT_CYCLES = 255
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              dbg_req_valid_i,
   output logic              dbg_req_ready_o,
   input  logic [3:0]        dbg_wen_i,
   input  logic [ADDR_W-1:0] dbg_addr_i,
   input  logic [DATA_W-1:0] dbg_wdata_i,
   output logic              dbg_rsp_valid_o,
   input  logic              dbg_rsp_ready_i,
   output logic [DATA_W-1:0] dbg_rdata_o,
   output logic              dbg_err_o,
   output logic              bus_req_valid_o,
   input  logic              bus_req_ready_i,
   output logic              bus_we_o,
   output logic [3:0]        bus_sel_o,
   output logic [ADDR_W-1:0] bus_addr_o,
   output logic [DATA_W-1:0] bus_wdata_o,
   input  logic              bus_rsp_valid_i,
   output logic              bus_rsp_ready_o,
   input  logic [DATA_W-1:0] bus_rdata_i,
   input  logic              bus_err_i,
   output logic              busy_o
);

   dbg_state_t        state_q, state_d;
   logic              accept, take_rsp, timeout;
   logic              to_expired, drain_q;
   logic              we_q;
   logic [3:0]        sel_q;
   logic [ADDR_W-1:0] addr_q;
   logic [DATA_W-1:0] wdata_q, rdata_q;
   logic              err_q;

`ifdef DBG_BRIDGE_TIMEOUT_EN
   logic cnt_clr, cnt_en;

   assign cnt_clr = accept && (state_d == ST_REQ);
   assign cnt_en  = (state_q == ST_REQ) || (state_q == ST_WAIT);

   dbg_timeout_cnt #(
      .LIMIT (TIMEOUT_CYCLES)
   ) u_timeout_cnt (
      .clk     (clk),
      .rst     (rst),
      .clr     (cnt_clr),
      .en      (cnt_en),
      .expired (to_expired)
   );

   // A timed-out WAIT leaves one response owed by the slave; swallow it before the next access.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         drain_q <= 1'b0;
      end else if (timeout && (state_q == ST_WAIT)) begin
         drain_q <= 1'b1;
      end else if (drain_q && bus_rsp_valid_i) begin
         drain_q <= 1'b0;
      end
   end
`else
   assign to_expired = 1'b0;
   assign drain_q    = 1'b0;
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      accept   = 1'b0;
      take_rsp = 1'b0;
      timeout  = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (dbg_req_valid_i && !drain_q) begin
               accept  = 1'b1;
               state_d = wen_legal(dbg_wen_i) ? ST_REQ : ST_RSP;
            end
         end
         ST_REQ: begin
            if (bus_req_ready_i) begin
               state_d = ST_WAIT;
            end else if (to_expired) begin
               timeout = 1'b1;
               state_d = ST_RSP;
            end
         end
         ST_WAIT: begin
            // A response seen while draining belongs to the abandoned access.
            if (bus_rsp_valid_i && !drain_q) begin
               take_rsp = 1'b1;
               state_d  = ST_RSP;
            end else if (to_expired) begin
               timeout = 1'b1;
               state_d = ST_RSP;
            end
         end
         ST_RSP: begin
            if (dbg_rsp_ready_i) begin
               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         we_q    <= 1'b0;
         sel_q   <= '0;
         addr_q  <= '0;
         wdata_q <= '0;
         rdata_q <= '0;
         err_q   <= 1'b0;
      end else begin
         if (accept) begin
            we_q    <= |dbg_wen_i;
            sel_q   <= (|dbg_wen_i) ? dbg_wen_i : SEL_WORD;
            addr_q  <= dbg_addr_i & {{(ADDR_W-2){1'b1}}, 2'b00};
            wdata_q <= dbg_wdata_i;
            rdata_q <= '0;
            err_q   <= !wen_legal(dbg_wen_i);
         end
         if (take_rsp) begin
            rdata_q <= (we_q || bus_err_i) ? '0 : bus_rdata_i;
            err_q   <= bus_err_i;
         end
         if (timeout) begin
            rdata_q <= '0;
            err_q   <= 1'b1;
         end
      end
   end

   assign dbg_req_ready_o = (state_q == ST_IDLE) && !drain_q;
   assign dbg_rsp_valid_o = (state_q == ST_RSP);
   assign dbg_rdata_o     = dbg_rsp_valid_o ? rdata_q : '0;
   assign dbg_err_o       = dbg_rsp_valid_o && err_q;
   assign bus_req_valid_o = (state_q == ST_REQ);
   assign bus_we_o        = we_q;
   assign bus_sel_o       = sel_q;
   assign bus_addr_o      = addr_q;
   assign bus_wdata_o     = wdata_q;
   assign bus_rsp_ready_o = (state_q == ST_WAIT) || drain_q;
   assign busy_o          = (state_q != ST_IDLE);

endmodule

// File: tb/tb_dbg_bus_bridge.sv
// Self-checking bench for dbg_bus_bridge: transaction-level timeline model, per-cycle compare, directed literals.
module tb_dbg_bus_bridge;

   localparam int T = 8;
`ifdef DBG_BRIDGE_TIMEOUT_EN
   localparam bit TO_ON = 1'b1;
`else
   localparam bit TO_ON = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst;
   logic        dbg_req_valid_i, dbg_req_ready_o;
   logic [3:0]  dbg_wen_i;
   logic [31:0] dbg_addr_i, dbg_wdata_i;
   logic        dbg_rsp_valid_o, dbg_rsp_ready_i;
   logic [31:0] dbg_rdata_o;
   logic        dbg_err_o;
   logic        bus_req_valid_o, bus_req_ready_i, bus_we_o;
   logic [3:0]  bus_sel_o;
   logic [31:0] bus_addr_o, bus_wdata_o;
   logic        bus_rsp_valid_i, bus_rsp_ready_o;
   logic [31:0] bus_rdata_i;
   logic        bus_err_i, busy_o;

   dbg_bus_bridge #(
      .ADDR_W         (32),
      .DATA_W         (32),
      .TIMEOUT_CYCLES (T)
   ) dut (
      .clk             (clk),
      .rst             (rst),
      .dbg_req_valid_i (dbg_req_valid_i),
      .dbg_req_ready_o (dbg_req_ready_o),
      .dbg_wen_i       (dbg_wen_i),
      .dbg_addr_i      (dbg_addr_i),
      .dbg_wdata_i     (dbg_wdata_i),
      .dbg_rsp_valid_o (dbg_rsp_valid_o),
      .dbg_rsp_ready_i (dbg_rsp_ready_i),
      .dbg_rdata_o     (dbg_rdata_o),
      .dbg_err_o       (dbg_err_o),
      .bus_req_valid_o (bus_req_valid_o),
      .bus_req_ready_i (bus_req_ready_i),
      .bus_we_o        (bus_we_o),
      .bus_sel_o       (bus_sel_o),
      .bus_addr_o      (bus_addr_o),
      .bus_wdata_o     (bus_wdata_o),
      .bus_rsp_valid_i (bus_rsp_valid_i),
      .bus_rsp_ready_o (bus_rsp_ready_o),
      .bus_rdata_i     (bus_rdata_i),
      .bus_err_i       (bus_err_i),
      .busy_o          (busy_o)
   );

   always #5 clk = ~clk;

   int n_tests = 0;
   int n_fail  = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at t=%0t", name, act, exp, $time);
      end
   endtask

   // Expected outputs for the current cycle, written by the transaction model.
   bit          chk_en = 1'b0;
   logic        e_busy, e_req_ready, e_rsp_valid, e_bus_req_valid, e_bus_rsp_ready;
   logic        e_we, e_err;
   logic [3:0]  e_sel;
   logic [31:0] e_addr, e_wdata, e_rdata;

   always @(negedge clk) begin
      if (chk_en) begin
         chk("busy", {31'd0, busy_o}, {31'd0, e_busy});
         chk("dbg_req_ready", {31'd0, dbg_req_ready_o}, {31'd0, e_req_ready});
         chk("dbg_rsp_valid", {31'd0, dbg_rsp_valid_o}, {31'd0, e_rsp_valid});
         chk("bus_req_valid", {31'd0, bus_req_valid_o}, {31'd0, e_bus_req_valid});
         chk("bus_rsp_ready", {31'd0, bus_rsp_ready_o}, {31'd0, e_bus_rsp_ready});
         if (e_rsp_valid) begin
            chk("dbg_rdata", dbg_rdata_o, e_rdata);
            chk("dbg_err", {31'd0, dbg_err_o}, {31'd0, e_err});
         end
         if (e_bus_req_valid) begin
            chk("bus_addr", bus_addr_o, e_addr);
            chk("bus_sel", {28'd0, bus_sel_o}, {28'd0, e_sel});
            chk("bus_we", {31'd0, bus_we_o}, {31'd0, e_we});
            chk("bus_wdata", bus_wdata_o, e_wdata);
         end
      end
   end

   task automatic idle_inputs();
      dbg_req_valid_i = 1'b0;
      dbg_wen_i       = '0;
      dbg_addr_i      = '0;
      dbg_wdata_i     = '0;
      dbg_rsp_ready_i = 1'b0;
      bus_req_ready_i = 1'b0;
      bus_rsp_valid_i = 1'b0;
      bus_rdata_i     = '0;
      bus_err_i       = 1'b0;
   endtask

   task automatic check_reset(input string tag);
      chk({tag, "_busy"}, {31'd0, busy_o}, 32'd0);
      chk({tag, "_req_ready"}, {31'd0, dbg_req_ready_o}, 32'd1);
      chk({tag, "_rsp_valid"}, {31'd0, dbg_rsp_valid_o}, 32'd0);
      chk({tag, "_rdata"}, dbg_rdata_o, 32'd0);
      chk({tag, "_err"}, {31'd0, dbg_err_o}, 32'd0);
      chk({tag, "_bus_req_valid"}, {31'd0, bus_req_valid_o}, 32'd0);
      chk({tag, "_bus_rsp_ready"}, {31'd0, bus_rsp_ready_o}, 32'd0);
      chk({tag, "_bus_we"}, {31'd0, bus_we_o}, 32'd0);
      chk({tag, "_bus_sel"}, {28'd0, bus_sel_o}, 32'd0);
      chk({tag, "_bus_addr"}, bus_addr_o, 32'd0);
      chk({tag, "_bus_wdata"}, bus_wdata_o, 32'd0);
   endtask

   // One access: request in cycle 0; slave raises req_ready in cycle 1+a, responds b cycles
   // after accepting; the debugger takes the response h cycles after it first appears.
   task automatic run_txn(input logic [3:0] wen, input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [31:0] rd, input logic berr, input int a, input int b, input int h,
                          output int rsp_cyc, output int nreq, output logic [31:0] g_addr,
                          output logic [31:0] g_wdata, output logic [31:0] g_rdata,
                          output logic [3:0] g_sel, output logic g_we, output logic g_err);
      bit legal, we, req_to, wait_to, slave_acc;
      int hs1, hs2, req_last, wait_last, rsp_start, rsp_end, last;
      legal     = wen inside {4'b0000, 4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0011, 4'b1100, 4'b1111};
      we        = |wen;
      hs1       = 1 + a;
      hs2       = 2 + a + b;
      req_to    = legal && TO_ON && (hs1 > T);
      wait_to   = legal && TO_ON && !req_to && (hs2 > T);
      slave_acc = legal && !req_to;
      if (!legal) begin
         rsp_start = 1; e_err = 1'b1; e_rdata = '0;
      end else if (req_to || wait_to) begin
         rsp_start = T + 1; e_err = 1'b1; e_rdata = '0;
      end else begin
         rsp_start = hs2 + 1; e_err = berr; e_rdata = (we || berr) ? 32'd0 : rd;
      end
      req_last  = req_to ? T : hs1;
      wait_last = wait_to ? T : hs2;
      rsp_end   = rsp_start + h;
      last      = (wait_to && hs2 > rsp_end) ? hs2 : rsp_end;
      e_we      = we;
      e_sel     = we ? wen : 4'b1111;
      e_addr    = {addr[31:2], 2'b00};
      e_wdata   = wdata;
      rsp_cyc = -1; nreq = 0;
      g_addr = '0; g_wdata = '0; g_rdata = '0; g_sel = '0; g_we = 1'b0; g_err = 1'b0;
      chk_en = 1'b1;
      for (int k = 0; k <= last; k++) begin
         dbg_req_valid_i = (k == 0);
         dbg_wen_i       = (k == 0) ? wen : 4'($urandom);
         dbg_addr_i      = (k == 0) ? addr : $urandom;
         dbg_wdata_i     = (k == 0) ? wdata : $urandom;
         bus_req_ready_i = legal && (k == hs1);
         bus_rsp_valid_i = slave_acc && (k == hs2);
         bus_rdata_i     = (k == hs2) ? rd : $urandom;
         bus_err_i       = (k == hs2) ? berr : 1'($urandom_range(0, 1));
         dbg_rsp_ready_i = (k == rsp_end);
         e_busy          = (k >= 1) && (k <= rsp_end);
         e_bus_req_valid = legal && (k >= 1) && (k <= req_last);
         e_bus_rsp_ready = (slave_acc && k > hs1 && k <= wait_last) || (wait_to && k > T && k <= hs2);
         e_rsp_valid     = (k >= rsp_start) && (k <= rsp_end);
         e_req_ready     = (k == 0) || (k > rsp_end && !(wait_to && k <= hs2));
         @(negedge clk);
         if (dbg_rsp_valid_o && rsp_cyc < 0) begin
            rsp_cyc = k; g_rdata = dbg_rdata_o; g_err = dbg_err_o;
         end
         if (bus_req_valid_o) begin
            if (nreq == 0) begin
               g_addr = bus_addr_o; g_wdata = bus_wdata_o; g_sel = bus_sel_o; g_we = bus_we_o;
            end
            nreq++;
         end
         @(posedge clk);
         #1;
      end
      chk_en = 1'b0;
      idle_inputs();
   endtask

   int          rc, nr;
   logic [31:0] ga, gw, gr;
   logic [3:0]  gs;
   logic        gwe, ge;
   logic [3:0]  legal_tab [8] = '{4'b0000, 4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0011, 4'b1100, 4'b1111};

   initial begin
      idle_inputs();
      rst = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      check_reset("reset");
      rst = 1'b0;
      @(posedge clk);
      #1;

      run_txn(4'b0000, 32'h1000_0004, 32'h0, 32'hCAFE_F00D, 1'b0, 0, 0, 0, rc, nr, ga, gw, gr, gs, gwe, ge);
      chk("rd_rsp_cycle", rc, 32'd3);
      chk("rd_bus_addr", ga, 32'h1000_0004);
      chk("rd_bus_sel", {28'd0, gs}, 32'hF);
      chk("rd_bus_we", {31'd0, gwe}, 32'd0);
      chk("rd_rdata", gr, 32'hCAFE_F00D);
      chk("rd_err", {31'd0, ge}, 32'd0);
      chk("rd_nreq", nr, 32'd1);

      run_txn(4'b1100, 32'h2000_0003, 32'h1234_5678, 32'hDEAD_BEEF, 1'b0, 3, 0, 0, rc, nr, ga, gw, gr, gs, gwe, ge);
      chk("wr_rsp_cycle", rc, 32'd6);
      chk("wr_bus_addr", ga, 32'h2000_0000);
      chk("wr_bus_sel", {28'd0, gs}, 32'hC);
      chk("wr_bus_we", {31'd0, gwe}, 32'd1);
      chk("wr_bus_wdata", gw, 32'h1234_5678);
      chk("wr_rdata", gr, 32'd0);
      chk("wr_err", {31'd0, ge}, 32'd0);
      chk("wr_nreq", nr, 32'd4);

      run_txn(4'b0101, 32'h0000_0010, 32'h1111_2222, 32'h3333_4444, 1'b0, 0, 0, 0, rc, nr, ga, gw, gr, gs, gwe, ge);
      chk("ill_rsp_cycle", rc, 32'd1);
      chk("ill_err", {31'd0, ge}, 32'd1);
      chk("ill_rdata", gr, 32'd0);
      chk("ill_nreq", nr, 32'd0);

`ifdef DBG_BRIDGE_TIMEOUT_EN
      run_txn(4'b0000, 32'h4000_0000, 32'h0, 32'h7777_7777, 1'b0, 0, 12, 0, rc, nr, ga, gw, gr, gs, gwe, ge);
      chk("to_wait_rsp_cycle", rc, 32'd9);
      chk("to_wait_err", {31'd0, ge}, 32'd1);
      chk("to_wait_rdata", gr, 32'd0);
      run_txn(4'b0000, 32'h4000_0008, 32'h0, 32'h0BAD_BEEF, 1'b0, 0, 0, 0, rc, nr, ga, gw, gr, gs, gwe, ge);
      chk("after_to_rsp_cycle", rc, 32'd3);
      chk("after_to_rdata", gr, 32'h0BAD_BEEF);
      chk("after_to_err", {31'd0, ge}, 32'd0);
      run_txn(4'b1111, 32'h4000_0010, 32'h5A5A_5A5A, 32'h0, 1'b0, 10, 0, 0, rc, nr, ga, gw, gr, gs, gwe, ge);
      chk("to_req_rsp_cycle", rc, 32'd9);
      chk("to_req_err", {31'd0, ge}, 32'd1);
      chk("to_req_nreq", nr, 32'd8);
`endif

      run_txn(4'b0000, 32'h5000_0000, 32'h0, 32'h55AA_55AA, 1'b1, 0, 0, 5, rc, nr, ga, gw, gr, gs, gwe, ge);
      chk("berr_rsp_cycle", rc, 32'd3);
      chk("berr_err", {31'd0, ge}, 32'd1);
      chk("berr_rdata", gr, 32'd0);

      // Reset while the bridge sits in WAIT.
      dbg_req_valid_i = 1'b1; dbg_wen_i = 4'b0000; dbg_addr_i = 32'h6000_0000;
      @(posedge clk); #1;
      idle_inputs();
      bus_req_ready_i = 1'b1;
      @(posedge clk); #1;
      bus_req_ready_i = 1'b0;
      @(posedge clk); #1;
      @(posedge clk); #1;
      chk("pre_rst_bus_rsp_ready", {31'd0, bus_rsp_ready_o}, 32'd1);
      #2 rst = 1'b1;
      #1 check_reset("mid_rst");
      @(posedge clk); #1;
      rst = 1'b0;
      @(posedge clk); #1;
      run_txn(4'b0000, 32'h3000_0008, 32'h0, 32'h600D_F00D, 1'b0, 0, 0, 0, rc, nr, ga, gw, gr, gs, gwe, ge);
      chk("post_rst_rsp_cycle", rc, 32'd3);
      chk("post_rst_rdata", gr, 32'h600D_F00D);
      chk("post_rst_addr", ga, 32'h3000_0008);

      for (int i = 0; i < 40; i++) begin
         logic [3:0] w;
         int a, b, h;
         w = ($urandom_range(0, 4) == 0) ? 4'($urandom) : legal_tab[$urandom_range(0, 7)];
         a = $urandom_range(0, 3);
         b = $urandom_range(0, 3);
         if ($urandom_range(0, 5) == 0) begin
            a = $urandom_range(0, 11);
            b = $urandom_range(0, 11);
         end
         h = $urandom_range(0, 3);
         run_txn(w, $urandom, $urandom, $urandom, ($urandom_range(0, 5) == 0), a, b, h,
                 rc, nr, ga, gw, gr, gs, gwe, ge);
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
